// File: rtl/lcd_rx_capture.sv
// ============================================================================
// Module   : lcd_rx_capture
// Purpose  : RGB565 DE-mode LCD receiver; coordinate-tagged pixel stream,
//            frame timing measurement and lock detection.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lcd_rx_capture #(
    parameter int EXP_H_DISP  = 800,
    parameter int EXP_V_DISP  = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        lcd_pclk,
    input  logic        rst_n,
    input  logic        lcd_de,
    input  logic        lcd_hs,
    input  logic        lcd_vs,
    input  logic [15:0] lcd_rgb,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        sof,
    output logic        eol,
    output logic [10:0] meas_h_disp,
    output logic [10:0] meas_v_disp,
    output logic [10:0] meas_h_total,
    output logic [10:0] meas_v_total,
    output logic        locked,
    output logic        timing_err
);

    typedef enum logic [1:0] {
        S_WAIT_VS = 2'd0,
        S_MEASURE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    localparam logic [10:0] c_SAT   = 11'h7FF;
    localparam logic [10:0] c_EXP_H = 11'(EXP_H_DISP);
    localparam logic [10:0] c_EXP_V = 11'(EXP_V_DISP);
    localparam logic [3:0]  c_LOCK  = 4'(LOCK_FRAMES);

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == c_SAT) ? v : v + 11'd1;
    endfunction

    logic        r_de1, r_hs1, r_vs1;
    logic        r_de2, r_hs2, r_vs2;
    logic [15:0] r_rgb1;
    logic [10:0] r_h_cnt, r_h_last, r_v_cnt, r_run_cnt, r_first_run, r_y_cnt;
    logic        r_have_run, r_run_bad, r_have_prev;
    state_t      r_state, w_state_nx;
    logic [3:0]  r_good_cnt, w_good_nx, w_good_inc;
    logic        w_locked_nx, w_err_nx;

    logic        w_hs_rise, w_vs_rise, w_de_rise, w_de_fall;
    logic        w_active, w_eval, w_pix;
    logic [10:0] w_hdisp_fin, w_vdisp_fin, w_htot_fin, w_vtot_fin;
    logic [10:0] w_x_nx, w_y_nx;
    logic        w_run_bad_fin, w_basic_ok, w_totals_eq, w_match;

    assign w_hs_rise = r_hs1 & ~r_hs2;
    assign w_vs_rise = r_vs1 & ~r_vs2;
    assign w_de_rise = r_de1 & ~r_de2;
    assign w_de_fall = ~r_de1 & r_de2;
    assign w_active  = (r_state != S_WAIT_VS);
    assign w_eval    = w_active & w_vs_rise;
    assign w_pix     = w_active & r_de1;

    // Closing-frame values fold in a de_fall/hs_rise landing on the vs_rise cycle.
    assign w_run_bad_fin = r_run_bad | (w_de_fall & r_have_run & (r_run_cnt != r_first_run));
    assign w_hdisp_fin   = (w_de_fall & ~r_have_run) ? r_run_cnt : r_first_run;
    assign w_vdisp_fin   = w_de_fall ? sat_inc(r_y_cnt) : r_y_cnt;
    assign w_htot_fin    = w_hs_rise ? r_h_cnt : r_h_last;
    assign w_vtot_fin    = r_v_cnt;

    assign w_basic_ok  = ~w_run_bad_fin
                       & (w_hdisp_fin == c_EXP_H) & (w_hdisp_fin != c_SAT)
                       & (w_vdisp_fin == c_EXP_V) & (w_vdisp_fin != c_SAT)
                       & (w_htot_fin != c_SAT) & (w_vtot_fin != c_SAT);
    assign w_totals_eq = r_have_prev & (w_htot_fin == meas_h_total)
                       & (w_vtot_fin == meas_v_total);
    assign w_match     = w_basic_ok & w_totals_eq;

    assign w_x_nx = w_de_rise ? 11'd0 : sat_inc(pix_x);
    assign w_y_nx = w_vs_rise ? 11'd0 : r_y_cnt;

    always_comb begin
        w_state_nx  = r_state;
        w_good_nx   = r_good_cnt;
        w_locked_nx = locked;
        w_err_nx    = 1'b0;
        w_good_inc  = (r_good_cnt == 4'hF) ? r_good_cnt : r_good_cnt + 4'd1;
        case (r_state)
            S_WAIT_VS: begin
                w_good_nx   = 4'd0;
                w_locked_nx = 1'b0;
                if (w_vs_rise) w_state_nx = S_MEASURE;
            end
            S_MEASURE: begin
                if (w_vs_rise) begin
                    if (w_match) begin
                        w_good_nx = w_good_inc;
                        if (w_good_inc >= c_LOCK) begin
                            w_state_nx  = S_LOCKED;
                            w_locked_nx = 1'b1;
                        end
                    end else if (w_basic_ok & ~r_have_prev) begin
                        // First frame becomes the reference for the totals.
                        w_good_nx = 4'd1;
                    end else begin
                        w_good_nx = 4'd0;
                        w_err_nx  = 1'b1;
                    end
                end
            end
            S_LOCKED: begin
                if (w_vs_rise) begin
                    if (w_match) begin
                        w_good_nx = w_good_inc;
                    end else begin
                        w_good_nx   = 4'd0;
                        w_err_nx    = 1'b1;
                        w_locked_nx = 1'b0;
                        w_state_nx  = S_MEASURE;
                    end
                end
            end
            default: w_state_nx = S_WAIT_VS;
        endcase
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_WAIT_VS;
            r_good_cnt <= 4'd0;
            locked     <= 1'b0;
            timing_err <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_good_cnt <= w_good_nx;
            locked     <= w_locked_nx;
            timing_err <= w_err_nx;
        end
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_de1        <= 1'b0;
            r_hs1        <= 1'b0;
            r_vs1        <= 1'b0;
            r_de2        <= 1'b0;
            r_hs2        <= 1'b0;
            r_vs2        <= 1'b0;
            r_rgb1       <= 16'd0;
            r_h_cnt      <= 11'd0;
            r_h_last     <= 11'd0;
            r_v_cnt      <= 11'd0;
            r_run_cnt    <= 11'd0;
            r_first_run  <= 11'd0;
            r_y_cnt      <= 11'd0;
            r_have_run   <= 1'b0;
            r_run_bad    <= 1'b0;
            r_have_prev  <= 1'b0;
            meas_h_disp  <= 11'd0;
            meas_v_disp  <= 11'd0;
            meas_h_total <= 11'd0;
            meas_v_total <= 11'd0;
            pix_valid    <= 1'b0;
            pix_data     <= 16'd0;
            pix_x        <= 11'd0;
            pix_y        <= 11'd0;
            sof          <= 1'b0;
            eol          <= 1'b0;
        end else begin
            r_de1  <= lcd_de;
            r_hs1  <= lcd_hs;
            r_vs1  <= lcd_vs;
            r_rgb1 <= lcd_rgb;
            r_de2  <= r_de1;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;

            if (w_hs_rise) begin
                r_h_cnt  <= 11'd1;
                r_h_last <= r_h_cnt;
            end else begin
                r_h_cnt <= sat_inc(r_h_cnt);
            end

            if (r_de1) r_run_cnt <= w_de_rise ? 11'd1 : sat_inc(r_run_cnt);

            if (w_vs_rise) begin
                r_v_cnt     <= w_hs_rise ? 11'd1 : 11'd0;
                r_y_cnt     <= 11'd0;
                r_have_run  <= 1'b0;
                r_run_bad   <= 1'b0;
                r_first_run <= 11'd0;
            end else begin
                if (w_hs_rise) r_v_cnt <= sat_inc(r_v_cnt);
                if (w_de_fall) begin
                    r_y_cnt <= sat_inc(r_y_cnt);
                    if (!r_have_run) begin
                        r_first_run <= r_run_cnt;
                        r_have_run  <= 1'b1;
                    end else if (r_run_cnt != r_first_run) begin
                        r_run_bad <= 1'b1;
                    end
                end
            end

            if (w_eval) begin
                meas_h_disp  <= w_hdisp_fin;
                meas_v_disp  <= w_vdisp_fin;
                meas_h_total <= w_htot_fin;
                meas_v_total <= w_vtot_fin;
                r_have_prev  <= 1'b1;
            end else if (!w_active) begin
                r_have_prev <= 1'b0;
            end

            pix_valid <= w_pix;
            sof       <= 1'b0;
            eol       <= 1'b0;
            if (w_pix) begin
                pix_data <= r_rgb1;
                pix_x    <= w_x_nx;
                pix_y    <= w_y_nx;
                sof      <= (w_x_nx == 11'd0) && (w_y_nx == 11'd0);
                eol      <= ~lcd_de;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lcd_rx_capture.sv
// ============================================================================
// Module   : tb_lcd_rx_capture
// Purpose  : Scoreboard bench for lcd_rx_capture on a small 25x13 timing.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lcd_rx_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        de = 1'b0, hs = 1'b0, vs = 1'b0;
    logic [15:0] rgb = 16'd0;

    logic        pix_valid, sof, eol, locked, timing_err;
    logic [15:0] pix_data;
    logic [10:0] pix_x, pix_y, m_hd, m_vd, m_ht, m_vt;
    logic        pix_valid_b, sof_b, eol_b, locked_b, timing_err_b;
    logic [15:0] pix_data_b;
    logic [10:0] pix_x_b, pix_y_b, m_hd_b, m_vd_b, m_ht_b, m_vt_b;

    always #5 clk = ~clk;

    lcd_rx_capture #(.EXP_H_DISP(16), .EXP_V_DISP(8), .LOCK_FRAMES(2)) dut (
        .lcd_pclk(clk), .rst_n(rst_n), .lcd_de(de), .lcd_hs(hs), .lcd_vs(vs),
        .lcd_rgb(rgb), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .sof(sof), .eol(eol),
        .meas_h_disp(m_hd), .meas_v_disp(m_vd), .meas_h_total(m_ht),
        .meas_v_total(m_vt), .locked(locked), .timing_err(timing_err)
    );

    lcd_rx_capture #(.EXP_H_DISP(16), .EXP_V_DISP(9), .LOCK_FRAMES(2)) dut_v9 (
        .lcd_pclk(clk), .rst_n(rst_n), .lcd_de(de), .lcd_hs(hs), .lcd_vs(vs),
        .lcd_rgb(rgb), .pix_valid(pix_valid_b), .pix_data(pix_data_b),
        .pix_x(pix_x_b), .pix_y(pix_y_b), .sof(sof_b), .eol(eol_b),
        .meas_h_disp(m_hd_b), .meas_v_disp(m_vd_b), .meas_h_total(m_ht_b),
        .meas_v_total(m_vt_b), .locked(locked_b), .timing_err(timing_err_b)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [10:0] x;
        logic [10:0] y;
        logic        sof;
        logic        eol;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0, n_fail = 0;
    int   cyc = 0;
    logic push_en = 1'b0, sb_en = 1'b0;
    int   n_valid = 0, n_sof = 0, n_eol = 0;
    int   err_pulses = 0, err_cycles = 0, err2_pulses = 0;
    logic err_prev = 1'b0, err2_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every valid output pixel must match the oldest expectation.
    always @(negedge clk) begin
        exp_t o, e;
        if (sb_en && rst_n === 1'b1) begin
            if (pix_valid) begin
                n_valid++;
                if (sof) n_sof++;
                if (eol) n_eol++;
                n_tests++;
                o = '{d: pix_data, x: pix_x, y: pix_y, sof: sof, eol: eol, cyc: cyc};
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pixel_unexpected: got x=%0d y=%0d d=%h at cyc %0d, required no pixel",
                             pix_x, pix_y, pix_data, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (o !== e) begin
                        n_fail++;
                        $display("FAIL pixel: got d=%h x=%0d y=%0d sof=%0b eol=%0b cyc=%0d, required d=%h x=%0d y=%0d sof=%0b eol=%0b cyc=%0d",
                                 o.d, o.x, o.y, o.sof, o.eol, o.cyc, e.d, e.x, e.y, e.sof, e.eol, e.cyc);
                    end
                end
            end
            if (timing_err) err_cycles++;
            if (timing_err && !err_prev) err_pulses++;
            if (timing_err_b && !err2_prev) err2_pulses++;
            err_prev  = timing_err;
            err2_prev = timing_err_b;
        end
    end

    task automatic drive(input logic d, input logic h, input logic v, input logic [15:0] p,
                         input int x, input int y, input logic last);
        exp_t e;
        @(negedge clk);
        de = d; hs = h; vs = v; rgb = p;
        if (d && push_en) begin
            e.d = p; e.x = 11'(x); e.y = 11'(y);
            e.sof = (x == 0) && (y == 0);
            e.eol = last;
            e.cyc = 32'(cyc + 2);
            sb_q.push_back(e);
        end
    endtask

    // Positions i0..i1-1 of a 25x13 frame: H sync4/back3/disp16/front2, V sync2/back2/disp8/front1.
    task automatic gen_span(input int i0, input int i1, input int short_row);
        for (int i = i0; i < i1; i++) begin
            int ln, c, x, y, w;
            logic d;
            logic [10:0] xv;
            logic [4:0]  yv;
            ln = i / 25; c = i % 25;
            x = c - 7;   y = ln - 4;
            w = (y == short_row) ? 15 : 16;
            d = (ln >= 4) && (ln <= 11) && (x >= 0) && (x < w);
            xv = 11'(x); yv = 5'(y);
            drive(d, c < 4, ln < 2, d ? {yv, xv} : 16'd0, x, y, d && (x == w - 1));
        end
    endtask

    task automatic gen_frame(input int short_row);
        gen_span(0, 325, short_row);
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({pix_valid, pix_data, pix_x, pix_y, sof, eol} !== 45'd0) begin
            n_fail++; $display("FAIL reset_pix: got %h, required 0", {pix_valid, pix_data, pix_x, pix_y, sof, eol});
        end
        n_tests++;
        if ({m_hd, m_vd, m_ht, m_vt} !== 44'd0) begin
            n_fail++; $display("FAIL reset_meas: got %h, required 0", {m_hd, m_vd, m_ht, m_vt});
        end
        n_tests++;
        if ({locked, timing_err, locked_b, pix_valid_b} !== 4'd0) begin
            n_fail++; $display("FAIL reset_flags: got %b, required 0000", {locked, timing_err, locked_b, pix_valid_b});
        end
        rst_n = 1'b1;
        sb_en = 1'b1;
        // DE activity with no preceding vs_rise must not be captured.
        gen_span(100, 300, -1);
        repeat (3) @(negedge clk);
        n_tests++;
        if (n_valid !== 0) begin
            n_fail++; $display("FAIL pre_vs_ignored: got %0d pixels, required 0", n_valid);
        end
    endtask

    task automatic test_lock;
        push_en = 1'b1;
        gen_frame(-1);
        gen_frame(-1);
        n_tests++;
        if (locked !== 1'b0) begin
            n_fail++; $display("FAIL lock_early: got locked=%b after 2 vs_rise, required 0", locked);
        end
        n_tests++;
        if ({m_hd, m_vd, m_ht, m_vt} !== {11'd16, 11'd8, 11'd25, 11'd13}) begin
            n_fail++; $display("FAIL meas: got %0d/%0d/%0d/%0d, required 16/8/25/13", m_hd, m_vd, m_ht, m_vt);
        end
        gen_frame(-1);
        n_tests++;
        if (locked !== 1'b1) begin
            n_fail++; $display("FAIL lock_3rd_vs: got locked=%b, required 1", locked);
        end
        n_tests++;
        if (err_pulses !== 0) begin
            n_fail++; $display("FAIL lock_no_err: got %0d timing_err pulses, required 0", err_pulses);
        end
    endtask

    task automatic test_pixel_stream;
        n_valid = 0; n_sof = 0; n_eol = 0;
        gen_frame(-1);
        n_tests++;
        if ({n_valid, n_sof, n_eol} !== {32'd128, 32'd1, 32'd8}) begin
            n_fail++; $display("FAIL frame_counts: got valid=%0d sof=%0d eol=%0d, required 128/1/8", n_valid, n_sof, n_eol);
        end
        n_tests++;
        if (sb_q.size() !== 0) begin
            n_fail++; $display("FAIL frame_drain: got %0d pending, required 0", sb_q.size());
        end
        n_tests++;
        if ({locked, m_ht, m_vt} !== {1'b1, 11'd25, 11'd13}) begin
            n_fail++; $display("FAIL lock_hold: got locked=%b ht=%0d vt=%0d, required 1/25/13", locked, m_ht, m_vt);
        end
    endtask

    task automatic test_timing_err;
        int ep, ec;
        ep = err_pulses; ec = err_cycles;
        gen_frame(3);
        gen_frame(-1);
        n_tests++;
        if ((err_pulses - ep) !== 1 || (err_cycles - ec) !== 1) begin
            n_fail++; $display("FAIL err_pulse: got %0d pulses %0d cycles, required 1/1", err_pulses - ep, err_cycles - ec);
        end
        n_tests++;
        if (locked !== 1'b0) begin
            n_fail++; $display("FAIL err_unlock: got locked=%b, required 0", locked);
        end
        gen_frame(-1);
        n_tests++;
        if (locked !== 1'b0) begin
            n_fail++; $display("FAIL relock_early: got locked=%b, required 0", locked);
        end
        gen_frame(-1);
        n_tests++;
        if (locked !== 1'b1 || (err_pulses - ep) !== 1) begin
            n_fail++; $display("FAIL relock: got locked=%b pulses=%0d, required 1/1", locked, err_pulses - ep);
        end
    endtask

    task automatic test_vdisp9;
        int e2;
        e2 = err2_pulses;
        repeat (3) gen_frame(-1);
        n_tests++;
        if ((err2_pulses - e2) !== 3) begin
            n_fail++; $display("FAIL v9_err: got %0d pulses, required 3", err2_pulses - e2);
        end
        n_tests++;
        if ({locked_b, m_hd_b, m_vd_b} !== {1'b0, 11'd16, 11'd8}) begin
            n_fail++; $display("FAIL v9_state: got locked=%b hd=%0d vd=%0d, required 0/16/8", locked_b, m_hd_b, m_vd_b);
        end
    endtask

    task automatic test_reset_mid;
        int ep;
        gen_frame(-1);
        gen_span(0, 6 * 25 + 12, -1);
        @(negedge clk);
        rst_n = 1'b0;
        push_en = 1'b0;
        sb_q.delete();
        #1;
        n_tests++;
        if ({pix_valid, pix_data, pix_x, pix_y, sof, eol, m_hd, m_vd, m_ht, m_vt, locked, timing_err} !== 91'd0) begin
            n_fail++; $display("FAIL mid_reset: got valid=%b x=%0d y=%0d locked=%b hd=%0d, required all 0",
                               pix_valid, pix_x, pix_y, locked, m_hd);
        end
        gen_span(6 * 25 + 13, 8 * 25, -1);
        rst_n = 1'b1;
        gen_span(8 * 25, 325, -1);
        ep = err_pulses;
        push_en = 1'b1;
        gen_frame(-1);
        gen_frame(-1);
        n_tests++;
        if (locked !== 1'b0) begin
            n_fail++; $display("FAIL mid_lock_early: got locked=%b after 2 vs_rise, required 0", locked);
        end
        gen_frame(-1);
        n_tests++;
        if (locked !== 1'b1 || err_pulses !== ep) begin
            n_fail++; $display("FAIL mid_relock: got locked=%b pulses=%0d, required 1/0", locked, err_pulses - ep);
        end
    endtask

    task automatic test_saturation;
        int ep;
        ep = err_pulses;
        for (int i = 0; i < 10; i++) drive(1'b0, i < 4, 1'b1, 16'd0, 0, 0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0, 16'd0, 0, 0, 1'b0);
        for (int i = 0; i < 3000; i++)
            drive(1'b1, 1'b0, 1'b0, 16'(i), (i > 2047) ? 2047 : i, 0, i == 2999);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0, 16'd0, 0, 0, 1'b0);
        n_tests++;
        if (pix_x !== 11'd2047) begin
            n_fail++; $display("FAIL sat_pix_x: got %0d, required 2047", pix_x);
        end
        gen_frame(-1);
        n_tests++;
        if (m_hd !== 11'd2047) begin
            n_fail++; $display("FAIL sat_meas: got meas_h_disp=%0d, required 2047", m_hd);
        end
        n_tests++;
        if ((err_pulses - ep) !== 1 || locked !== 1'b0) begin
            n_fail++; $display("FAIL sat_err: got pulses=%0d locked=%b, required 1/0", err_pulses - ep, locked);
        end
        n_tests++;
        if (sb_q.size() !== 0) begin
            n_fail++; $display("FAIL sat_drain: got %0d pending, required 0", sb_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lock();
        test_pixel_stream();
        test_timing_err();
        test_vdisp9();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
